// File: rtl/merger_input_fifo.sv
// First-word-fall-through input FIFO feeding one merger input port.
// Head word is presented combinationally from storage; flags derive from the registered count.
module merger_input_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    input  logic                  rd,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_CNT    = (DEPTH_LOG2 + 1)'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  pop, push, drop;

    assign valid       = (count_q != '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign overflow    = overflow_q;
    assign count       = count_q;
    assign dout        = mem_q[rd_ptr_q];

    // A same-edge pop frees a slot, so a full FIFO can still accept a write.
    assign pop  = en && rd && valid;
    assign push = en && wr_en && (!full || pop);
    assign drop = en && wr_en && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || drop;
        if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        if (push && !pop)
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        else if (pop && !push)
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never cleared; a reset edge only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: tb/tb_merger_input_fifo.sv
// Directed bench for merger_input_fifo: vector table plus hand sequences for fill/overflow/hold.
module tb_merger_input_fifo;
    logic        clk = 1'b0;
    logic        reset, en, wr_en, rd;
    logic [11:0] din, dout;
    logic        full, almost_full, overflow, valid;
    logic [4:0]  count;
    int          checks = 0;
    int          errors = 0;

    merger_input_fifo #(.DATA_WIDTH(12), .DEPTH_LOG2(4), .AF_LEVEL(14)) dut (
        .clk(clk), .reset(reset), .en(en), .din(din), .wr_en(wr_en),
        .full(full), .almost_full(almost_full), .overflow(overflow),
        .dout(dout), .valid(valid), .rd(rd), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, en, wr, rd;
        logic [11:0] din;
        logic        e_valid;
        logic [11:0] e_dout;
        logic        chk_dout;
        logic [4:0]  e_count;
        logic        e_full, e_af, e_ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic step(input logic r, input logic e, input logic w, input logic p, input logic [11:0] d);
        reset = r; en = e; wr_en = w; rd = p; din = d;
        @(posedge clk);
        #1;
        reset = 1'b1; en = 1'b1; wr_en = 1'b0; rd = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [4:0] c,
                             input logic f, input logic af, input logic o);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".full"}, 32'(full), 32'(f));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".overflow"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; wr_en = 1'b0; rd = 1'b0; din = '0;
        //            rst en wr rd din     valid dout   cd cnt full af ovf
        vecs[0]  = '{1'b0,1,0,0,12'h000, 1'b0,12'h000,0, 5'd0, 0,0,0};
        vecs[1]  = '{1'b1,1,1,0,12'h0A1, 1'b1,12'h0A1,1, 5'd1, 0,0,0};
        vecs[2]  = '{1'b1,1,1,0,12'h0B2, 1'b1,12'h0A1,1, 5'd2, 0,0,0};
        vecs[3]  = '{1'b1,1,1,0,12'h0C3, 1'b1,12'h0A1,1, 5'd3, 0,0,0};
        vecs[4]  = '{1'b1,1,0,1,12'h000, 1'b1,12'h0B2,1, 5'd2, 0,0,0};
        vecs[5]  = '{1'b1,1,0,1,12'h000, 1'b1,12'h0C3,1, 5'd1, 0,0,0};
        vecs[6]  = '{1'b1,1,0,1,12'h000, 1'b0,12'h000,0, 5'd0, 0,0,0};
        vecs[7]  = '{1'b1,1,0,1,12'h000, 1'b0,12'h000,0, 5'd0, 0,0,0};
        vecs[8]  = '{1'b1,1,1,0,12'h044, 1'b1,12'h044,1, 5'd1, 0,0,0};
        vecs[9]  = '{1'b1,1,1,1,12'h055, 1'b1,12'h055,1, 5'd1, 0,0,0};
        vecs[10] = '{1'b1,0,1,1,12'h066, 1'b1,12'h055,1, 5'd1, 0,0,0};
        vecs[11] = '{1'b1,1,0,1,12'h000, 1'b0,12'h000,0, 5'd0, 0,0,0};

        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_count,
                      vecs[i].e_full, vecs[i].e_af, vecs[i].e_ovf);
            if (vecs[i].chk_dout) chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].e_dout));
        end

        // Fill to full, then a dropped write sets sticky overflow.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 12'h100 + 12'(i));
            chk($sformatf("fill%0d.count", i), 32'(count), i + 1);
            chk($sformatf("fill%0d.almost_full", i), 32'(almost_full), 32'(i + 1 >= 14));
        end
        chk_state("full", 1'b1, 5'd16, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF);
        chk_state("drop", 1'b1, 5'd16, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.dout", i), 32'(dout), 32'(12'h100 + 12'(i)));
            step(1'b1, 1'b1, 1'b0, 1'b1, '0);
        end
        chk_state("drained", 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Full with a same-edge write and pop: accepted, pointers wrap.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk_state("rst2", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 12'h200 + 12'(i));
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h123);
        chk_state("wrpop_full", 1'b1, 5'd16, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("wrap_pop%0d.dout", i), 32'(dout),
                32'((i == 16) ? 12'h123 : 12'h200 + 12'(i)));
            step(1'b1, 1'b1, 1'b0, 1'b1, '0);
        end
        chk_state("wrap_empty", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Overflow set, count brought to 5, then hold under en=0 and reset with en=0.
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 12'h300 + 12'(i));
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b1, '0);
        chk_state("five", 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        chk("five.dout", 32'(dout), 32'(12'h30B));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 12'hABC);
            chk_state($sformatf("hold%0d", i), 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
            chk($sformatf("hold%0d.dout", i), 32'(dout), 32'(12'h30B));
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 12'hABC);
        chk_state("rst_en0", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
